// File: rtl/tff_mod_counter.sv
// Up/down modulus counter built from a bank of toggle flip-flops.
// The arithmetic next state is computed first, and each bit toggles wherever it differs from the current state.
module tff_bit (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    logic q_q, q_d;

    always_comb q_d = q_q ^ t;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;
endmodule

module tff_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
            $error("tff_mod_counter: illegal WIDTH/MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] cnt, cnt_nxt, t;
    logic             evt;
    logic             wrap_q, wrap_d, ovf_q, ovf_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            tff_bit u_bit (.clk(clk), .rst(rst), .t(t[i]), .q(cnt[i]));
        end
    endgenerate

    assign tc  = en & ((up & (cnt == MAXV)) | (!up & (cnt == '0)));
    assign evt = en & !clr & !load & tc;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAXV : load_val;
        end else if (en) begin
            if (up) begin
                if (cnt == MAXV) cnt_nxt = SATURATE ? cnt : '0;
                else             cnt_nxt = cnt + WIDTH'(1);
            end else begin
                if (cnt == '0)   cnt_nxt = SATURATE ? cnt : MAXV;
                else             cnt_nxt = cnt - WIDTH'(1);
            end
        end
        t = cnt ^ cnt_nxt;
    end

    always_comb begin
        wrap_d = evt;
        ovf_d  = clr ? 1'b0 : (ovf_q | evt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = cnt;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
endmodule
